// File: rtl/ro_measure_ctrl_if.sv
// ro_measure_ctrl_if
// Host-side handshake between the host/scan logic and the ring-oscillator
// measurement sequencer.
//   start    host -> ctrl  single-cycle measurement request
//   abort    host -> ctrl  cancel the measurement in progress
//   win_len  host -> ctrl  window length in clk cycles
//   cont     host -> ctrl  keep measuring back-to-back windows (RO_CONT_EN only)
//   busy     ctrl -> host  settling or measuring
//   done     ctrl -> host  one-cycle pulse when count/overflow update
//   count    ctrl -> host  last completed result
//   overflow ctrl -> host  last completed result saturated
// Optional feature macro: RO_CONT_EN (adds cont).
`timescale 1ns/1ps
interface ro_measure_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) ();
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
`ifdef RO_CONT_EN
  logic             cont;
`endif
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

`ifdef RO_CONT_EN
  modport master (
    output start, abort, win_len, cont,
    input  busy, done, count, overflow
  );
  modport slave (
    input  start, abort, win_len, cont,
    output busy, done, count, overflow
  );
`else
  modport master (
    output start, abort, win_len,
    input  busy, done, count, overflow
  );
  modport slave (
    input  start, abort, win_len,
    output busy, done, count, overflow
  );
`endif
endinterface

// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl
// Measurement sequencer for one ring-oscillator tile. Enables the oscillator,
// lets it settle for SETTLE_CYCLES, counts rising edges of a prescaled copy of
// ro_out over win_len clk cycles, then publishes the result with a done pulse.
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   bus          host handshake (start/abort/win_len[/cont] in,
//                busy/done/count/overflow out)
//   ro_out       oscillator output, asynchronous to clk
//   ro_activate  oscillator enable (registered)
// Optional feature macro: RO_CONT_EN (continuous back-to-back windows).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | oscillator off, waiting for start with non-zero win_len
// S_SETTLE  | oscillator running, accumulator held clear, SETTLE_CYCLES long
// S_MEASURE | counting prescaler-MSB rising edges, win_len cycles long
// S_DONE    | one cycle: result published, done pulses
`timescale 1ns/1ps
module ro_measure_ctrl #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int DIV_BITS      = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  ro_measure_ctrl_if.slave bus,
  input  logic             ro_out,
  output logic             ro_activate
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0]       tmr, tmr_nxt, tmr_win;
  logic [WIN_W-1:0]       win_q;
  logic [CNT_W-1:0]       acc, acc_nxt, count_q;
  logic                   sat, sat_nxt;
  logic                   overflow_q, done_q, busy_q;
  logic                   accept, win_ld, acc_clr, res_ld;
  logic                   cont_run, busy_nxt, act_nxt;

  logic [DIV_BITS-1:0]    pre_q;
  logic                   pre_clr;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q, msb_rise;

`ifdef RO_CONT_EN
  assign cont_run = bus.cont;
`else
  assign cont_run = 1'b0;
`endif

  // A start that coincides with abort is dropped; a zero-length window is
  // never accepted.
  assign accept  = bus.start && (bus.win_len != '0) && !bus.abort;
  assign tmr_win = TMR_W'(win_q) - TMR_W'(1);

  // -------------------------------------------------------------------------
  // Prescaler in the ro_out domain. Held in clear whenever the oscillator is
  // disabled so every run starts from the same phase.
  // -------------------------------------------------------------------------
  assign pre_clr = rst | ~ro_activate;

  always_ff @(posedge ro_out or posedge pre_clr) begin
    if (pre_clr) pre_q <= '0;
    else         pre_q <= pre_q + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Synchroniser + rising-edge detect of the prescaler MSB in the clk domain.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else if (!ro_activate) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pre_q[DIV_BITS-1]};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign msb_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // -------------------------------------------------------------------------
  // FSM: state and window/settle down-counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    win_ld    = 1'b0;
    acc_clr   = 1'b0;
    res_ld    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SETTLE;
          tmr_nxt   = TMR_SETTLE;
          win_ld    = 1'b1;
        end
      end
      S_SETTLE: begin
        acc_clr = 1'b1;
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (tmr == '0) begin
          state_nxt = S_MEASURE;
          tmr_nxt   = tmr_win;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_MEASURE: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (tmr == '0) begin
          state_nxt = S_DONE;
          res_ld    = 1'b1;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_DONE: begin
        if (cont_run && !bus.abort) begin
          // Back-to-back window: the oscillator is already settled.
          state_nxt = S_MEASURE;
          tmr_nxt   = tmr_win;
          acc_clr   = 1'b1;
        end else if (accept) begin
          state_nxt = S_SETTLE;
          tmr_nxt   = TMR_SETTLE;
          win_ld    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Accumulator with saturation. The result register loads the post-update
  // value so the edge seen in the last MEASURE cycle is not lost.
  // -------------------------------------------------------------------------
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat;
    if ((state == S_MEASURE) && msb_rise) begin
      if (&acc) sat_nxt = 1'b1;
      else      acc_nxt = acc + 1'b1;
    end
  end

  // Outputs are registered from the next state so ro_activate, which feeds
  // the prescaler's asynchronous clear, is glitch-free. In continuous mode
  // the enable stays up through DONE when cont was high on entry.
  assign busy_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE);
  assign act_nxt  = busy_nxt || ((state_nxt == S_DONE) && cont_run);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ro_activate <= 1'b0;
    end else begin
      if (win_ld) win_q <= bus.win_len;
      if (acc_clr) begin
        acc <= '0;
        sat <= 1'b0;
      end else begin
        acc <= acc_nxt;
        sat <= sat_nxt;
      end
      if (res_ld) begin
        count_q    <= acc_nxt;
        overflow_q <= sat_nxt;
      end
      done_q      <= (state_nxt == S_DONE);
      busy_q      <= busy_nxt;
      ro_activate <= act_nxt;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

  a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
    !(done_q && busy_q));
  a_done_single : assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);

endmodule

// File: tb/tb_ro_measure_ctrl.sv
`timescale 1ns/1ps
module tb_ro_measure_ctrl;

  localparam int  CNT_W    = 5;
  localparam int  WIN_W    = 16;
  localparam int  SETTLE   = 8;
  localparam int  DIV_BITS = 4;
  localparam int  CNT_MAX  = (1 << CNT_W) - 1;
  localparam real T_CLK    = 20.0;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic ro_out = 1'b0;
  logic ro_activate;
  real  ro_hp  = 2.5;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;
  int exp_ovf = 0;

  ro_measure_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  ro_measure_ctrl #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYCLES(SETTLE),
    .DIV_BITS(DIV_BITS), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .ro_out(ro_out), .ro_activate(ro_activate)
  );

  always #10 clk = ~clk;

  initial begin
    forever begin
      #(ro_hp);
      ro_out = ~ro_out;
    end
  end

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: number of prescaler-MSB periods that fit in a window of
  // win clk cycles, from the frequency ratio alone.
  function automatic real model_edges(input int win, input real hp);
    return (win * T_CLK) / ((2.0 ** DIV_BITS) * 2.0 * hp);
  endfunction

  task automatic model_result(input int win);
    real e;
    e = model_edges(win, ro_hp);
    if (e > CNT_MAX + 1.0) begin
      exp_cnt = CNT_MAX;
      exp_ovf = 1;
    end else begin
      exp_cnt = $rtoi(e + 0.5);
      exp_ovf = 0;
    end
  endtask

  // Runs one measurement and returns in the DONE cycle (1 ns after the edge).
  // A second start with another win_len is pulsed during SETTLE; it must be
  // ignored, so latency and result follow the first win_len.
  task automatic run_meas(input int win, input bit in_done_cycle);
    int n;
    int gaps;
    bit seen;
    if (!in_done_cycle) @(negedge clk);
    bus.win_len = WIN_W'(win);
    bus.start   = 1'b1;
    model_result(win);
    n = 0; gaps = 0; seen = 1'b0;
    while (!seen && n < SETTLE + win + 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        check("act_rise", int'(ro_activate), 1);
        check("busy_rise", int'(bus.busy), 1);
      end
      if (n == 3) begin
        bus.start   = 1'b1;
        bus.win_len = WIN_W'(win + 7);
      end
      if (n == 4) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (!ro_activate) gaps++;
    end
    check("done_seen", int'(seen), 1);
    check("latency", n, 1 + SETTLE + win);
    check("act_gap", gaps, 0);
    check("act_in_done", int'(ro_activate), 0);
    check("busy_in_done", int'(bus.busy), 0);
    check("count", int'(bus.count), exp_cnt, exp_ovf ? 0 : 1);
    check("overflow", int'(bus.overflow), exp_ovf);
  endtask

  task automatic idle_check(input int cycles);
    int dn;
    int bz;
    dn = 0; bz = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
      if (bus.busy) bz++;
    end
    check("idle_done", dn, 0);
    check("idle_busy", bz, 0);
  endtask

`ifdef RO_CONT_EN
  task automatic run_cont();
    int n;
    int gaps;
    ro_hp = 2.5;
    idle_check(4);
    @(negedge clk);
    bus.win_len = WIN_W'(40);
    bus.cont    = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("cont_first_lat", n, 1 + SETTLE + 40);
    check("cont_count0", int'(bus.count), 10, 1);
    for (int w = 0; w < 4; w++) begin
      if (w == 3) begin
        @(negedge clk);
        bus.cont = 1'b0;
      end
      n = 0; gaps = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (!ro_activate) gaps++;
      end while (!bus.done && n < 100);
      check("cont_period", n, 41);
      check("cont_busy_done", int'(bus.busy), 0);
      check("cont_count", int'(bus.count), 10, 1);
      if (w < 3) check("cont_act_const", gaps, 0);
    end
    @(posedge clk); #1;
    check("cont_stop_busy", int'(bus.busy), 0);
    check("cont_stop_act", int'(ro_activate), 0);
    idle_check(50);
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached before the run ended");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hp_i;
    int win;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.win_len = '0;
`ifdef RO_CONT_EN
    bus.cont    = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_act", int'(ro_activate), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(4);

    // f_ro = 4 f_clk, window 100 -> 25
    ro_hp = 2.5;
    run_meas(100, 1'b0);
    idle_check(3);

    // Zero-length window is ignored
    @(negedge clk);
    bus.win_len = '0;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle_check(30);
    check("win0_count", int'(bus.count), exp_cnt, 1);

    // start together with abort in IDLE is dropped
    @(negedge clk);
    bus.win_len = WIN_W'(50);
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abst_act", int'(ro_activate), 0);
    idle_check(5);

    // Abort 5 cycles into MEASURE
    @(negedge clk);
    bus.win_len = WIN_W'(100);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (SETTLE + 5) @(posedge clk);
    #1;
    check("busy_pre_abort", int'(bus.busy), 1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_act", int'(ro_activate), 0);
    check("abort_busy", int'(bus.busy), 0);
    idle_check(150);
    check("abort_count", int'(bus.count), exp_cnt, 1);
    check("abort_ovf", int'(bus.overflow), exp_ovf);

    // Saturation, then a normal short window
    run_meas(200, 1'b0);
    idle_check(2);
    run_meas(20, 1'b0);

    // start in the DONE cycle is accepted
    run_meas(60, 1'b1);
    idle_check(2);

    // Reset pulse in the middle of MEASURE
    @(negedge clk);
    bus.win_len = WIN_W'(100);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_act", int'(ro_activate), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.done), 0);
    check("mrst_count", int'(bus.count), 0);
    check("mrst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(3);
    run_meas(100, 1'b0);
    idle_check(2);

    // Randomised oscillator frequency and window
    for (int i = 0; i < 8; i++) begin
      hp_i  = $urandom_range(3, 20);
      ro_hp = real'(hp_i);
      idle_check(4);
      win = $urandom_range(16, 40 * hp_i);
      run_meas(win, 1'b0);
      idle_check(2);
    end

`ifdef RO_CONT_EN
    run_cont();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
